// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one single-port data RAM between the instruction-fetch
//            port (IFU, read-only) and the load/store port (LSU, read/write).
//            Every request runs IDLE -> ACCESS -> RESP. The LSU normally wins,
//            but an IFU that has lost MAX_WAIT arbitrations in a row is forced
//            to win the next one.
// Ports    : clk, rst_n                  - clock, async active-low reset
//            ifu_req_* / ifu_rsp_*       - IFU valid/ready request + response
//            lsu_req_* / lsu_rsp_*       - LSU valid/ready request + response
//            lsu_rsp_err_o               - illegal LSU request flag
//            ram_addr_o/ewr_o/data_o/wid_o, ram_data_i - RAM interface
//                                          (ewr 0=write, comb read)
// Options  : `define MEM_ARB_ERR_EN to flag illegal LSU requests
//            (wid==7, or store with wid>=4). They are then never written and
//            answer with err=1 and data=0. Without it, err is always 0.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int RAM_SIZE   = 16,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ifu_req_valid_i,
    output logic                  ifu_req_ready_o,
    input  logic [RAM_SIZE-1:0]   ifu_addr_i,
    output logic                  ifu_rsp_valid_o,
    input  logic                  ifu_rsp_ready_i,
    output logic [DATA_WIDTH-1:0] ifu_rsp_data_o,
    input  logic                  lsu_req_valid_i,
    output logic                  lsu_req_ready_o,
    input  logic [RAM_SIZE-1:0]   lsu_addr_i,
    input  logic                  lsu_we_i,
    input  logic [2:0]            lsu_wid_i,
    input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
    output logic                  lsu_rsp_valid_o,
    input  logic                  lsu_rsp_ready_i,
    output logic [DATA_WIDTH-1:0] lsu_rsp_data_o,
    output logic                  lsu_rsp_err_o,
    output logic [RAM_SIZE-1:0]   ram_addr_o,
    output logic                  ram_ewr_o,
    output logic [DATA_WIDTH-1:0] ram_data_o,
    output logic [2:0]            ram_wid_o,
    input  logic [DATA_WIDTH-1:0] ram_data_i
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [2:0] c_WID_D    = 3'd3;
    localparam logic [2:0] c_WID_WU   = 3'd6;
    localparam logic [3:0] c_MAX_WAIT = 4'(MAX_WAIT);

    state_t                r_state_q,         w_state_d;
    logic                  r_own_lsu_q,       w_own_lsu_d;
    logic [RAM_SIZE-1:0]   r_addr_q,          w_addr_d;
    logic                  r_we_q,            w_we_d;
    logic [2:0]            r_wid_q,           w_wid_d;
    logic [DATA_WIDTH-1:0] r_wdata_q,         w_wdata_d;
    logic [3:0]            r_starve_q,        w_starve_d;
    logic                  r_ifu_rsp_valid_q, w_ifu_rsp_valid_d;
    logic                  r_lsu_rsp_valid_q, w_lsu_rsp_valid_d;
    logic [DATA_WIDTH-1:0] r_ifu_rsp_data_q,  w_ifu_rsp_data_d;
    logic [DATA_WIDTH-1:0] r_lsu_rsp_data_q,  w_lsu_rsp_data_d;
    logic                  r_lsu_rsp_err_q,   w_lsu_rsp_err_d;

    logic w_lsu_win;
    logic w_ifu_win;
    logic w_idle;
    logic w_illegal;

    // Starved IFU overrides the LSU's fixed priority.
    assign w_lsu_win = lsu_req_valid_i && !(ifu_req_valid_i && (r_starve_q == c_MAX_WAIT));
    assign w_ifu_win = ifu_req_valid_i && !w_lsu_win;
    // rst_n gates the combinational readies so they drop with the reset edge.
    assign w_idle    = (r_state_q == S_IDLE) && rst_n;

    assign lsu_req_ready_o = w_idle && w_lsu_win;
    assign ifu_req_ready_o = w_idle && w_ifu_win;

`ifdef MEM_ARB_ERR_EN
    assign w_illegal = r_own_lsu_q && ((r_wid_q == 3'd7) || (r_we_q && r_wid_q[2]));
`else
    assign w_illegal = 1'b0;
`endif

    // Write enable only inside ACCESS; every other state reads.
    assign ram_ewr_o  = !((r_state_q == S_ACCESS) && r_we_q && !w_illegal);
    assign ram_addr_o = r_addr_q;
    assign ram_wid_o  = r_wid_q;
    assign ram_data_o = r_wdata_q;

    assign ifu_rsp_valid_o = r_ifu_rsp_valid_q;
    assign ifu_rsp_data_o  = r_ifu_rsp_data_q;
    assign lsu_rsp_valid_o = r_lsu_rsp_valid_q;
    assign lsu_rsp_data_o  = r_lsu_rsp_data_q;
    assign lsu_rsp_err_o   = r_lsu_rsp_err_q;

    always_comb begin
        w_state_d         = r_state_q;
        w_own_lsu_d       = r_own_lsu_q;
        w_addr_d          = r_addr_q;
        w_we_d            = r_we_q;
        w_wid_d           = r_wid_q;
        w_wdata_d         = r_wdata_q;
        w_starve_d        = r_starve_q;
        w_ifu_rsp_valid_d = r_ifu_rsp_valid_q;
        w_lsu_rsp_valid_d = r_lsu_rsp_valid_q;
        w_ifu_rsp_data_d  = r_ifu_rsp_data_q;
        w_lsu_rsp_data_d  = r_lsu_rsp_data_q;
        w_lsu_rsp_err_d   = r_lsu_rsp_err_q;
        case (r_state_q)
            S_IDLE: begin
                if (w_lsu_win) begin
                    w_state_d   = S_ACCESS;
                    w_own_lsu_d = 1'b1;
                    w_addr_d    = lsu_addr_i;
                    w_we_d      = lsu_we_i;
                    w_wid_d     = lsu_wid_i;
                    w_wdata_d   = lsu_wdata_i;
                    if (ifu_req_valid_i && (r_starve_q != c_MAX_WAIT)) begin
                        w_starve_d = r_starve_q + 4'd1;
                    end
                end else if (w_ifu_win) begin
                    w_state_d   = S_ACCESS;
                    w_own_lsu_d = 1'b0;
                    w_addr_d    = ifu_addr_i;
                    w_we_d      = 1'b0;
                    w_wid_d     = c_WID_WU;
                    w_wdata_d   = '0;
                    w_starve_d  = 4'd0;
                end
            end
            S_ACCESS: begin
                w_state_d = S_RESP;
                if (r_own_lsu_q) begin
                    w_lsu_rsp_valid_d = 1'b1;
                    w_lsu_rsp_err_d   = w_illegal;
                    w_lsu_rsp_data_d  = (r_we_q || w_illegal) ? '0 : ram_data_i;
                end else begin
                    w_ifu_rsp_valid_d = 1'b1;
                    w_ifu_rsp_data_d  = ram_data_i;
                end
            end
            S_RESP: begin
                if (r_own_lsu_q && lsu_rsp_ready_i) begin
                    w_lsu_rsp_valid_d = 1'b0;
                    w_state_d         = S_IDLE;
                end else if (!r_own_lsu_q && ifu_rsp_ready_i) begin
                    w_ifu_rsp_valid_d = 1'b0;
                    w_state_d         = S_IDLE;
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q         <= S_IDLE;
            r_own_lsu_q       <= 1'b0;
            r_addr_q          <= '0;
            r_we_q            <= 1'b0;
            r_wid_q           <= c_WID_D;
            r_wdata_q         <= '0;
            r_starve_q        <= 4'd0;
            r_ifu_rsp_valid_q <= 1'b0;
            r_lsu_rsp_valid_q <= 1'b0;
            r_ifu_rsp_data_q  <= '0;
            r_lsu_rsp_data_q  <= '0;
            r_lsu_rsp_err_q   <= 1'b0;
        end else begin
            r_state_q         <= w_state_d;
            r_own_lsu_q       <= w_own_lsu_d;
            r_addr_q          <= w_addr_d;
            r_we_q            <= w_we_d;
            r_wid_q           <= w_wid_d;
            r_wdata_q         <= w_wdata_d;
            r_starve_q        <= w_starve_d;
            r_ifu_rsp_valid_q <= w_ifu_rsp_valid_d;
            r_lsu_rsp_valid_q <= w_lsu_rsp_valid_d;
            r_ifu_rsp_data_q  <= w_ifu_rsp_data_d;
            r_lsu_rsp_data_q  <= w_lsu_rsp_data_d;
            r_lsu_rsp_err_q   <= w_lsu_rsp_err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter. A RAM model answers the
//            arbiter; a transaction-level reference model predicts winners,
//            latency and response contents, pushing expected responses into
//            per-port queues that a separate monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    localparam int DW   = 64;
    localparam int AW   = 16;
    localparam int MAXW = 4;
`ifdef MEM_ARB_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ifu_req_valid_i = 1'b0, ifu_req_ready_o;
    logic [AW-1:0] ifu_addr_i = '0;
    logic          ifu_rsp_valid_o, ifu_rsp_ready_i = 1'b0;
    logic [DW-1:0] ifu_rsp_data_o;
    logic          lsu_req_valid_i = 1'b0, lsu_req_ready_o;
    logic [AW-1:0] lsu_addr_i = '0;
    logic          lsu_we_i = 1'b0;
    logic [2:0]    lsu_wid_i = 3'd0;
    logic [DW-1:0] lsu_wdata_i = '0;
    logic          lsu_rsp_valid_o, lsu_rsp_ready_i = 1'b0;
    logic [DW-1:0] lsu_rsp_data_o;
    logic          lsu_rsp_err_o;
    logic [AW-1:0] ram_addr_o;
    logic          ram_ewr_o;
    logic [DW-1:0] ram_data_o;
    logic [2:0]    ram_wid_o;
    logic [DW-1:0] ram_data_i;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_WIDTH(DW), .RAM_SIZE(AW), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid_i(ifu_req_valid_i), .ifu_req_ready_o(ifu_req_ready_o),
        .ifu_addr_i(ifu_addr_i), .ifu_rsp_valid_o(ifu_rsp_valid_o),
        .ifu_rsp_ready_i(ifu_rsp_ready_i), .ifu_rsp_data_o(ifu_rsp_data_o),
        .lsu_req_valid_i(lsu_req_valid_i), .lsu_req_ready_o(lsu_req_ready_o),
        .lsu_addr_i(lsu_addr_i), .lsu_we_i(lsu_we_i), .lsu_wid_i(lsu_wid_i),
        .lsu_wdata_i(lsu_wdata_i), .lsu_rsp_valid_o(lsu_rsp_valid_o),
        .lsu_rsp_ready_i(lsu_rsp_ready_i), .lsu_rsp_data_o(lsu_rsp_data_o),
        .lsu_rsp_err_o(lsu_rsp_err_o), .ram_addr_o(ram_addr_o),
        .ram_ewr_o(ram_ewr_o), .ram_data_o(ram_data_o), .ram_wid_o(ram_wid_o),
        .ram_data_i(ram_data_i)
    );

    // ---------------- RAM semantics (width code behaviour) ----------------
    function automatic logic [63:0] rd_ext(input logic [63:0] w, input logic [2:0] wid);
        case (wid)
            3'd0:    return {{56{w[7]}},  w[7:0]};
            3'd1:    return {{48{w[15]}}, w[15:0]};
            3'd2:    return {{32{w[31]}}, w[31:0]};
            3'd3:    return w;
            3'd4:    return {56'd0, w[7:0]};
            3'd5:    return {48'd0, w[15:0]};
            3'd6:    return {32'd0, w[31:0]};
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] wr_merge(input logic [63:0] old, input logic [63:0] nw,
                                             input logic [2:0] wid);
        case (wid)
            3'd0:    return {old[63:8],  nw[7:0]};
            3'd1:    return {old[63:16], nw[15:0]};
            3'd2:    return {old[63:32], nw[31:0]};
            3'd3:    return nw;
            default: return old;
        endcase
    endfunction

    function automatic logic [63:0] init_val(input int i);
        if (i == 'h10) return 64'hAAAA_BBBB_1234_5678;
        return {32'(i) * 32'h9E37_79B9, ~(32'(i) * 32'h85EB_CA6B)};
    endfunction

    logic [63:0] ram [0:63];
    always_comb ram_data_i = (ram_addr_o < 16'd64) ? rd_ext(ram[ram_addr_o[5:0]], ram_wid_o) : 64'd0;

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (!ram_ewr_o && ram_addr_o < 16'd64)
                ram[ram_addr_o[5:0]] <= wr_merge(ram[ram_addr_o[5:0]], ram_data_o, ram_wid_o);
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {logic [63:0] data; logic err;} rsp_t;
    rsp_t ifu_q[$];
    rsp_t lsu_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    logic [63:0] ref_mem [0:63];
    bit          ifu_pend = 0, lsu_pend = 0;
    logic [15:0] ifu_a = '0, lsu_a = '0;
    bit          lsu_w = 0;
    logic [2:0]  lsu_wc = '0;
    logic [63:0] lsu_wd = '0;
    int          phase = 0;          // 0 idle, 1 RAM access cycle, 2 response pending
    bit          own_lsu = 0;
    logic [15:0] cur_a;
    bit          cur_we, cur_ill;
    logic [2:0]  cur_wid;
    logic [63:0] cur_wdata;
    int          lose_cnt = 0, streak = 0, max_streak = 0, bp_cnt = 0;
    logic [63:0] last_ifu_data = '0, last_lsu_data = '0;
    logic        last_lsu_err = 1'b0;

    function automatic bit is_illegal(input bit we, input logic [2:0] wid);
        return ERR_EN && ((wid == 3'd7) || (we && wid >= 3'd4));
    endfunction

    // mode: 0 random, 1 both always requesting, 2 long backpressure, 3 directed
    task automatic cycle(input int mode);
        bit   rdy;
        bit   exp_i, exp_l;
        rsp_t e;
        @(posedge clk); #1;
        if (mode != 3) begin
            if (!ifu_pend && (mode != 0 || $urandom_range(0, 1) == 1)) begin
                ifu_pend = 1;
                ifu_a    = 16'($urandom_range(0, 63));
            end
            if (!lsu_pend && (mode != 0 || $urandom_range(0, 1) == 1)) begin
                lsu_pend = 1;
                lsu_a    = 16'($urandom_range(0, 63));
                lsu_w    = 1'($urandom_range(0, 1));
                lsu_wc   = 3'($urandom_range(0, 7));
                lsu_wd   = {$urandom, $urandom};
            end
        end
        case (mode)
            0: rdy = ($urandom_range(0, 9) < 7);
            2: begin
                if (phase == 2) begin rdy = (bp_cnt >= 5); bp_cnt++; end
                else begin rdy = 0; bp_cnt = 0; end
            end
            default: rdy = 1;
        endcase
        ifu_rsp_ready_i = rdy;
        lsu_rsp_ready_i = rdy;
        ifu_req_valid_i = ifu_pend;
        ifu_addr_i      = ifu_a;
        lsu_req_valid_i = lsu_pend;
        lsu_addr_i      = lsu_a;
        lsu_we_i        = lsu_w;
        lsu_wid_i       = lsu_wc;
        lsu_wdata_i     = lsu_wd;
        #1;
        case (phase)
            0: begin
                exp_l = lsu_pend && !(ifu_pend && lose_cnt == MAXW);
                exp_i = ifu_pend && !exp_l;
                chk("ifu_req_ready", 64'(ifu_req_ready_o), 64'(exp_i));
                chk("lsu_req_ready", 64'(lsu_req_ready_o), 64'(exp_l));
                chk("ewr_idle", 64'(ram_ewr_o), 64'd1);
                chk("rsp_valid_idle", {62'd0, ifu_rsp_valid_o, lsu_rsp_valid_o}, 64'd0);
                if (exp_l) begin
                    own_lsu = 1; cur_a = lsu_a; cur_we = lsu_w; cur_wid = lsu_wc;
                    cur_wdata = lsu_wd; cur_ill = is_illegal(lsu_w, lsu_wc);
                    e.err = cur_ill;
                    if (lsu_w) begin
                        e.data = 64'd0;
                        if (!cur_ill) ref_mem[lsu_a[5:0]] = wr_merge(ref_mem[lsu_a[5:0]], lsu_wd, lsu_wc);
                    end else begin
                        e.data = cur_ill ? 64'd0 : rd_ext(ref_mem[lsu_a[5:0]], lsu_wc);
                    end
                    lsu_q.push_back(e);
                    if (ifu_pend) begin
                        if (lose_cnt < MAXW) lose_cnt++;
                        streak++;
                        if (streak > max_streak) max_streak = streak;
                    end
                    lsu_pend = 0;
                    phase = 1;
                end else if (exp_i) begin
                    own_lsu = 0; cur_a = ifu_a; cur_we = 0; cur_wid = 3'd6;
                    cur_wdata = 64'd0; cur_ill = 0;
                    e.data = rd_ext(ref_mem[ifu_a[5:0]], 3'd6);
                    e.err  = 1'b0;
                    ifu_q.push_back(e);
                    lose_cnt = 0; streak = 0;
                    ifu_pend = 0;
                    phase = 1;
                end
            end
            1: begin
                chk("req_ready_access", {62'd0, ifu_req_ready_o, lsu_req_ready_o}, 64'd0);
                chk("ewr_access", 64'(ram_ewr_o), 64'(!(cur_we && !cur_ill)));
                chk("ram_addr", 64'(ram_addr_o), 64'(cur_a));
                chk("ram_wid", 64'(ram_wid_o), 64'(cur_wid));
                if (cur_we) chk("ram_wdata", ram_data_o, cur_wdata);
                chk("rsp_valid_access", {62'd0, ifu_rsp_valid_o, lsu_rsp_valid_o}, 64'd0);
                phase = 2;
            end
            default: begin
                chk("req_ready_resp", {62'd0, ifu_req_ready_o, lsu_req_ready_o}, 64'd0);
                chk("ewr_resp", 64'(ram_ewr_o), 64'd1);
                chk("rsp_valid_resp", {62'd0, ifu_rsp_valid_o, lsu_rsp_valid_o},
                    own_lsu ? 64'd1 : 64'd2);
                if (own_lsu ? lsu_rsp_ready_i : ifu_rsp_ready_i) phase = 0;
            end
        endcase
    endtask

    // ---------------- monitor ----------------
    bit          ifu_hold = 0, lsu_hold = 0;
    logic [63:0] ifu_hold_d, lsu_hold_d;
    logic        lsu_hold_e;

    initial begin
        rsp_t g;
        forever begin
            @(posedge clk); #3;
            if (!rst_n) begin
                ifu_hold = 0; lsu_hold = 0;
            end else begin
                if (ifu_rsp_valid_o) begin
                    if (ifu_hold) chk("ifu_rsp_stable", ifu_rsp_data_o, ifu_hold_d);
                    if (ifu_rsp_ready_i) begin
                        ifu_hold = 0;
                        if (ifu_q.size() == 0) chk("ifu_rsp_unexpected", 64'd1, 64'd0);
                        else begin
                            g = ifu_q.pop_front();
                            chk("ifu_rsp_data", ifu_rsp_data_o, g.data);
                            last_ifu_data = ifu_rsp_data_o;
                        end
                    end else begin
                        ifu_hold = 1; ifu_hold_d = ifu_rsp_data_o;
                    end
                end else ifu_hold = 0;
                if (lsu_rsp_valid_o) begin
                    if (lsu_hold) chk("lsu_rsp_stable", {lsu_rsp_data_o[62:0], lsu_rsp_err_o},
                                      {lsu_hold_d[62:0], lsu_hold_e});
                    if (lsu_rsp_ready_i) begin
                        lsu_hold = 0;
                        if (lsu_q.size() == 0) chk("lsu_rsp_unexpected", 64'd1, 64'd0);
                        else begin
                            g = lsu_q.pop_front();
                            chk("lsu_rsp_data", lsu_rsp_data_o, g.data);
                            chk("lsu_rsp_err", 64'(lsu_rsp_err_o), 64'(g.err));
                            last_lsu_data = lsu_rsp_data_o;
                            last_lsu_err  = lsu_rsp_err_o;
                        end
                    end else begin
                        lsu_hold = 1; lsu_hold_d = lsu_rsp_data_o; lsu_hold_e = lsu_rsp_err_o;
                    end
                end else lsu_hold = 0;
            end
        end
    end

    task automatic issue_lsu(input logic [15:0] a, input bit we, input logic [2:0] wid,
                             input logic [63:0] wd);
        lsu_pend = 1; lsu_a = a; lsu_w = we; lsu_wc = wid; lsu_wd = wd;
        repeat (8) cycle(3);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, {62'd0, ifu_req_ready_o, lsu_req_ready_o}, 64'd0);
        chk({tag, "_rsp_valid"}, {62'd0, ifu_rsp_valid_o, lsu_rsp_valid_o}, 64'd0);
        chk({tag, "_ifu_data"}, ifu_rsp_data_o, 64'd0);
        chk({tag, "_lsu_data"}, lsu_rsp_data_o, 64'd0);
        chk({tag, "_err"}, 64'(lsu_rsp_err_o), 64'd0);
        chk({tag, "_ewr"}, 64'(ram_ewr_o), 64'd1);
        chk({tag, "_ram_addr"}, 64'(ram_addr_o), 64'd0);
        chk({tag, "_ram_wid"}, 64'(ram_wid_o), 64'd3);
        chk({tag, "_ram_data"}, ram_data_o, 64'd0);
    endtask

    initial begin
        logic [63:0] saved;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
        lsu_req_valid_i = 1'b1;             // readies must stay low during reset
        ifu_req_valid_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        lsu_req_valid_i = 1'b0;
        ifu_req_valid_i = 1'b0;
        rst_n = 1'b1;

        // IFU fetch of a word with non-zero upper half
        ifu_pend = 1; ifu_a = 16'h10;
        repeat (8) cycle(3);
        chk("ifu_fetch_0x10", last_ifu_data, 64'h0000_0000_1234_5678);

        // store doubleword then signed byte load
        issue_lsu(16'h20, 1, 3'd3, 64'hDEAD_BEEF_CAFE_F00D);
        chk("store_ack_data", last_lsu_data, 64'd0);
        issue_lsu(16'h20, 0, 3'd0, 64'd0);
        chk("load_b_0x20", last_lsu_data, 64'h0000_0000_0000_000D);

        // unsupported store width
        issue_lsu(16'h28, 1, 3'd4, 64'h1111_2222_3333_4444);
        chk("bu_store_err", 64'(last_lsu_err), 64'(ERR_EN));
        chk("bu_store_ram", ram[6'h28], init_val('h28));

        // both ports saturated: IFU must win after exactly MAXW losses
        max_streak = 0;
        repeat (90) cycle(1);
        chk("max_ifu_losses", 64'(max_streak), 64'(MAXW));

        repeat (90) cycle(2);
        repeat (1500) cycle(0);

        // drain outstanding traffic
        ifu_pend = 0; lsu_pend = 0;
        repeat (8) cycle(3);

        // reset while a store is in its RAM access cycle
        saved = ref_mem[6'h30];
        lsu_pend = 1; lsu_a = 16'h30; lsu_w = 1; lsu_wc = 3'd3; lsu_wd = 64'd1;
        cycle(3);
        @(posedge clk); #2;
        chk("pre_reset_store_ewr", 64'(ram_ewr_o), 64'd0);
        lsu_req_valid_i = 1'b1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(posedge clk); #1;
        chk("reset_ram_0x30", ram[6'h30], saved);
        ref_mem[6'h30] = saved;
        ifu_q.delete(); lsu_q.delete();
        phase = 0; lose_cnt = 0; streak = 0; ifu_pend = 0; lsu_pend = 0;
        lsu_req_valid_i = 1'b0; ifu_req_valid_i = 1'b0;
        rst_n = 1'b1;
        issue_lsu(16'h30, 0, 3'd3, 64'd0);
        chk("load_after_reset_0x30", last_lsu_data, saved);
        chk("queues_drained", 64'(ifu_q.size() + lsu_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
